// File: rtl/imem_controller.sv
// imem_controller
//   Sequencer and sole owner of the CPU instruction memory port. After reset
//   the block idles; it then either streams a program into memory (LOAD) or
//   fetches one instruction per cycle into a registered output (FETCH), with
//   stall, branch redirect and halt. Because the controller is the only driver
//   of the memory address/write lines, loader writes and fetches never collide.
//
// Ports
//   Clk, Rst_n                    clock, asynchronous active-low reset
//   Load_Start/Valid/Data/Last    loader byte stream; Load_Ready = accept
//   Run                           start execution at PC=0 (IDLE/HALTED only)
//   Cpu_Stall, Branch_Taken,      fetch control from the CPU
//   Branch_Target, Halt
//   Mem_Addr/WData/WE, Mem_RData  memory port (write on Clk rise, comb read)
//   PC                            next fetch address
//   Instr, Instr_PC, Instr_Valid  registered fetched instruction and its address
//   Cpu_Run                       high while fetching
//   Load_Done, Load_Err           sticky load status
//   Load_Count                    bytes written by the current/last load
module imem_controller #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Load_Start,
  input  logic              Load_Valid,
  input  logic [DATA_W-1:0] Load_Data,
  input  logic              Load_Last,
  output logic              Load_Ready,
  input  logic              Run,
  input  logic              Cpu_Stall,
  input  logic              Branch_Taken,
  input  logic [ADDR_W-1:0] Branch_Target,
  input  logic              Halt,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WData,
  output logic              Mem_WE,
  input  logic [DATA_W-1:0] Mem_RData,
  output logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] Instr,
  output logic [ADDR_W-1:0] Instr_PC,
  output logic              Instr_Valid,
  output logic              Cpu_Run,
  output logic              Load_Done,
  output logic              Load_Err,
  output logic [ADDR_W:0]   Load_Count
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_HALTED
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   load_count;
  logic              load_done;
  logic              load_err;
  logic [DATA_W-1:0] instr_p1;
  logic [ADDR_W-1:0] instr_pc_p1;
  logic              vld_p1;

  logic waiting;
  logic load_accept;
  logic fetch_adv;

  assign waiting     = (state == S_IDLE) || (state == S_HALTED);
  assign load_accept = (state == S_LOAD) && Load_Valid;
  // Normal fetch only when no higher-priority halt/branch/stall this cycle.
  assign fetch_adv   = (state == S_FETCH) && !Halt && !Branch_Taken && !Cpu_Stall;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    Load_Ready = 1'b0;
    Mem_WE     = 1'b0;
    Mem_WData  = '0;
    Mem_Addr   = pc;
    Cpu_Run    = 1'b0;
    case (state)
      S_IDLE, S_HALTED: begin
        // Load_Start wins over Run when both are asserted.
        if (Load_Start)  state_next = S_LOAD;
        else if (Run)    state_next = S_FETCH;
      end
      S_LOAD: begin
        Load_Ready = 1'b1;
        Mem_Addr   = ptr;
        Mem_WData  = Load_Data;
        Mem_WE     = Load_Valid;
        // Overflow: the byte at the last address is still written, then stop.
        if (Load_Valid && (Load_Last || ptr == ADDR_LAST)) state_next = S_IDLE;
      end
      S_FETCH: begin
        Cpu_Run = 1'b1;
        if (Halt) state_next = S_HALTED;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Load bookkeeping: pointer, byte count and sticky status flags.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ptr        <= '0;
      load_count <= '0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else if (waiting && Load_Start) begin
      ptr        <= '0;
      load_count <= '0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else if (load_accept) begin
      ptr        <= ptr + 1'b1;
      load_count <= load_count + 1'b1;
      if (Load_Last)              load_done <= 1'b1;
      else if (ptr == ADDR_LAST)  load_err  <= 1'b1;
    end
  end

  // Program counter: reset to 0 on Run, redirected by branch, held on
  // halt/stall, otherwise advanced alongside each fetch.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc <= '0;
    end else if (waiting && !Load_Start && Run) begin
      pc <= '0;
    end else if (state == S_FETCH && !Halt && Branch_Taken) begin
      pc <= Branch_Target;
    end else if (fetch_adv) begin
      pc <= pc + 1'b1;
    end
  end

  // Stage p1: registered instruction captured from the memory read of PC.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      instr_p1    <= '0;
      instr_pc_p1 <= '0;
      vld_p1      <= 1'b0;
    end else if (fetch_adv) begin
      instr_p1    <= Mem_RData;
      instr_pc_p1 <= pc;
      vld_p1      <= 1'b1;
    end else if (state != S_FETCH || Halt || Branch_Taken) begin
      // Squash on branch (wrong-path fetch) and never valid outside FETCH.
      vld_p1      <= 1'b0;
    end
  end

  assign PC          = pc;
  assign Instr       = instr_p1;
  assign Instr_PC    = instr_pc_p1;
  assign Instr_Valid = vld_p1;
  assign Load_Done   = load_done;
  assign Load_Err    = load_err;
  assign Load_Count  = load_count;

endmodule

// File: tb/tb_imem_controller.sv
// Testbench for imem_controller: drives directed load/run/branch/halt/reset
// sequences, keeps a 256x8 memory attached to the DUT memory port, and checks
// every output each cycle against a behavioural model plus literal expectations.
module tb_imem_controller;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b1;
  logic       Load_Start = 1'b0;
  logic       Load_Valid = 1'b0;
  logic [7:0] Load_Data = 8'h00;
  logic       Load_Last = 1'b0;
  logic       Load_Ready;
  logic       Run = 1'b0;
  logic       Cpu_Stall = 1'b0;
  logic       Branch_Taken = 1'b0;
  logic [7:0] Branch_Target = 8'h00;
  logic       Halt = 1'b0;
  logic [7:0] Mem_Addr;
  logic [7:0] Mem_WData;
  logic       Mem_WE;
  logic [7:0] Mem_RData;
  logic [7:0] PC;
  logic [7:0] Instr;
  logic [7:0] Instr_PC;
  logic       Instr_Valid;
  logic       Cpu_Run;
  logic       Load_Done;
  logic       Load_Err;
  logic [8:0] Load_Count;

  imem_controller #(.ADDR_W(8), .DATA_W(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Load_Start(Load_Start), .Load_Valid(Load_Valid), .Load_Data(Load_Data),
    .Load_Last(Load_Last), .Load_Ready(Load_Ready),
    .Run(Run), .Cpu_Stall(Cpu_Stall), .Branch_Taken(Branch_Taken),
    .Branch_Target(Branch_Target), .Halt(Halt),
    .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData), .Mem_WE(Mem_WE),
    .Mem_RData(Mem_RData), .PC(PC), .Instr(Instr), .Instr_PC(Instr_PC),
    .Instr_Valid(Instr_Valid), .Cpu_Run(Cpu_Run), .Load_Done(Load_Done),
    .Load_Err(Load_Err), .Load_Count(Load_Count)
  );

  always #5 Clk = ~Clk;

  // Memory attached to the DUT port.
  logic [7:0] mem [256];
  assign Mem_RData = mem[Mem_Addr];
  always @(posedge Clk) if (Mem_WE) mem[Mem_Addr] <= Mem_WData;

  // Write log for address checks.
  int we_q[$];
  always @(posedge Clk) if (Rst_n && Mem_WE) we_q.push_back(int'(Mem_Addr));

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 load, 2 fetch, 3 halted
  int m_mode = 0, m_pc = 0, m_ptr = 0, m_cnt = 0;
  int m_done = 0, m_err = 0, m_instr = 0, m_ipc = 0, m_vld = 0;
  int ref_mem [256];

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_mode = 0; m_pc = 0; m_ptr = 0; m_cnt = 0;
      m_done = 0; m_err = 0; m_instr = 0; m_ipc = 0; m_vld = 0;
    end else begin
      case (m_mode)
        0, 3: begin
          if (Load_Start) begin
            m_mode = 1; m_ptr = 0; m_cnt = 0; m_done = 0; m_err = 0;
          end else if (Run) begin
            m_mode = 2; m_pc = 0; m_vld = 0;
          end
        end
        1: if (Load_Valid) begin
          ref_mem[m_ptr] = int'(Load_Data);
          m_cnt = m_cnt + 1;
          if (Load_Last) begin m_done = 1; m_mode = 0; end
          else if (m_ptr == 255) begin m_err = 1; m_mode = 0; end
          m_ptr = (m_ptr + 1) % 256;
        end
        default: begin
          if (Halt) begin m_mode = 3; m_vld = 0; end
          else if (Branch_Taken) begin m_pc = int'(Branch_Target); m_vld = 0; end
          else if (!Cpu_Stall) begin
            m_instr = ref_mem[m_pc]; m_ipc = m_pc; m_vld = 1;
            m_pc = (m_pc + 1) % 256;
          end
        end
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("load_ready", int'(Load_Ready), int'(m_mode == 1));
      chk("mem_we", int'(Mem_WE), int'(m_mode == 1 && Load_Valid));
      chk("mem_addr", int'(Mem_Addr), (m_mode == 1) ? m_ptr : m_pc);
      if (m_mode == 1) chk("mem_wdata", int'(Mem_WData), int'(Load_Data));
      chk("cpu_run", int'(Cpu_Run), int'(m_mode == 2));
      chk("pc", int'(PC), m_pc);
      chk("instr_valid", int'(Instr_Valid), m_vld);
      chk("instr", int'(Instr), m_instr);
      chk("instr_pc", int'(Instr_PC), m_ipc);
      chk("load_done", int'(Load_Done), m_done);
      chk("load_err", int'(Load_Err), m_err);
      chk("load_count", int'(Load_Count), m_cnt);
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  logic [7:0] held_instr;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i) ^ 8'h5A;
      ref_mem[i] = int'(8'(i) ^ 8'h5A);
    end
    #2 Rst_n = 1'b0;
    chk_en = 1'b1;
    step(); step();
    chk("rst_pc", int'(PC), 0);
    chk("rst_valid", int'(Instr_Valid), 0);
    chk("rst_ready", int'(Load_Ready), 0);
    chk("rst_count", int'(Load_Count), 0);
    Rst_n = 1'b1;
    step();

    // Load 0x11,0x22,<gap>,0x33(last)
    we_q.delete();
    Load_Start = 1'b1; step(); Load_Start = 1'b0;
    Load_Valid = 1'b1; Load_Data = 8'h11; step();
    Load_Data = 8'h22; step();
    Load_Valid = 1'b0; step();
    Load_Valid = 1'b1; Load_Data = 8'h33; Load_Last = 1'b1; step();
    Load_Valid = 1'b0; Load_Last = 1'b0;
    chk("ld3_count", int'(Load_Count), 3);
    chk("ld3_done", int'(Load_Done), 1);
    chk("ld3_idle", int'(Load_Ready), 0);
    chk("ld3_we_pulses", we_q.size(), 3);
    if (we_q.size() == 3) begin
      chk("ld3_addr0", we_q[0], 0);
      chk("ld3_addr1", we_q[1], 1);
      chk("ld3_addr2", we_q[2], 2);
    end

    // Run: first valid two edges after Run sampled
    Run = 1'b1; step(); Run = 1'b0;
    chk("run_e1_valid", int'(Instr_Valid), 0);
    chk("run_e1_cpurun", int'(Cpu_Run), 1);
    step();
    chk("run_i0", int'(Instr), 8'h11); chk("run_pc0", int'(Instr_PC), 0);
    chk("run_v0", int'(Instr_Valid), 1);
    step();
    chk("run_i1", int'(Instr), 8'h22); chk("run_pc1", int'(Instr_PC), 1);
    step();
    chk("run_i2", int'(Instr), 8'h33); chk("run_pc2", int'(Instr_PC), 2);

    // Branch while stalled: branch overrides stall, one bubble
    Cpu_Stall = 1'b1; Branch_Taken = 1'b1; Branch_Target = 8'h80; step();
    Branch_Taken = 1'b0; Cpu_Stall = 1'b0;
    chk("br_bubble", int'(Instr_Valid), 0);
    chk("br_pc", int'(PC), 8'h80);
    step();
    chk("br_tgt_pc", int'(Instr_PC), 8'h80);
    chk("br_tgt_instr", int'(Instr), 8'h80 ^ 8'h5A);
    chk("br_tgt_valid", int'(Instr_Valid), 1);
    held_instr = Instr;
    Cpu_Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_instr", int'(Instr), int'(held_instr));
      chk("stall_ipc", int'(Instr_PC), 8'h80);
      chk("stall_pc", int'(PC), 8'h81);
    end
    Cpu_Stall = 1'b0;

    // Wrap-around from 0xFE; Load_Start during fetch is ignored
    Branch_Taken = 1'b1; Branch_Target = 8'hFE; step(); Branch_Taken = 1'b0;
    step(); chk("wrap_fe", int'(Instr_PC), 8'hFE);
    Load_Start = 1'b1;
    step(); chk("wrap_ff", int'(Instr_PC), 8'hFF);
    Load_Start = 1'b0;
    chk("fetch_ignores_load", int'(Load_Ready), 0);
    step(); chk("wrap_00", int'(Instr_PC), 8'h00);

    // Halt, then Load_Start+Run together -> LOAD
    Halt = 1'b1; step(); Halt = 1'b0;
    chk("halt_cpurun", int'(Cpu_Run), 0);
    chk("halt_valid", int'(Instr_Valid), 0);
    chk("halt_pc", int'(PC), 1);
    Load_Start = 1'b1; Run = 1'b1; step(); Load_Start = 1'b0; Run = 1'b0;
    chk("start_beats_run", int'(Load_Ready), 1);

    // 256 bytes without Last -> overflow
    we_q.delete();
    Load_Valid = 1'b1;
    for (int k = 0; k < 256; k++) begin
      Load_Data = 8'(k * 7 + 3);
      step();
    end
    Load_Valid = 1'b0;
    chk("ovf_err", int'(Load_Err), 1);
    chk("ovf_count", int'(Load_Count), 256);
    chk("ovf_done", int'(Load_Done), 0);
    chk("ovf_idle", int'(Load_Ready), 0);
    chk("ovf_writes", we_q.size(), 256);
    if (we_q.size() > 0) chk("ovf_last_addr", we_q[we_q.size() - 1], 8'hFF);

    // Fetch the freshly loaded program
    Run = 1'b1; step(); Run = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("reload_instr3", int'(Instr), 8'(3 * 7 + 3));

    // Halt, start a load, async reset mid-load
    Halt = 1'b1; step(); Halt = 1'b0;
    Load_Start = 1'b1; step(); Load_Start = 1'b0;
    Load_Valid = 1'b1; Load_Data = 8'hC3; step();
    Load_Data = 8'hD4;
    #2 Rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", int'(Load_Ready), 0);
    chk("rst_mid_we", int'(Mem_WE), 0);
    chk("rst_mid_count", int'(Load_Count), 0);
    chk("rst_mid_addr", int'(Mem_Addr), 0);
    chk("rst_mid_err", int'(Load_Err), 0);
    step();
    Load_Valid = 1'b0;
    chk("rst_mem_kept", int'(mem[1]), 8'(1 * 7 + 3));
    Rst_n = 1'b1;
    step(); step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
